// File: rtl/fetch_stage.sv
// Instruction-fetch stage for the WISC-S25 pipeline: PC register, imem address,
// IF/ID pipeline register, stall/flush handling and HLT detection.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] redirect_pc,
    input  logic [15:0] imem_data,
    output logic [15:0] imem_addr,
    output logic [15:0] pc,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_plus_2,
    output logic        if_id_valid,
    output logic        hlt,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        RUN,
        HALT_PEND,
        HALTED
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pc_nxt, instr_nxt, pp2_nxt, count_nxt;
    logic        valid_nxt;
    logic [15:0] pc_plus_2;
    logic        is_hlt;

    assign pc_plus_2 = pc + 16'd2;
    assign is_hlt    = (imem_data[15:12] == 4'hF);
    assign imem_addr = pc;
    assign hlt       = (state == HALTED);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = if_id_instr;
        pp2_nxt   = if_id_pc_plus_2;
        valid_nxt = if_id_valid;
        count_nxt = fetch_count;
        case (state)
            RUN, HALT_PEND: begin
                if (flush) begin
                    state_nxt = RUN;
                    pc_nxt    = {redirect_pc[15:1], 1'b0};
                    instr_nxt = NOP_INSTR;
                    pp2_nxt   = '0;
                    valid_nxt = 1'b0;
                end else if (!stall) begin
                    if (state == RUN) begin
                        // HLT enters IF/ID like any instruction but freezes the PC.
                        instr_nxt = imem_data;
                        pp2_nxt   = pc_plus_2;
                        valid_nxt = 1'b1;
                        count_nxt = fetch_count + 16'd1;
                        if (is_hlt) state_nxt = HALT_PEND;
                        else        pc_nxt    = pc_plus_2;
                    end else begin
                        state_nxt = HALTED;
                        instr_nxt = NOP_INSTR;
                        pp2_nxt   = '0;
                        valid_nxt = 1'b0;
                    end
                end
            end
            HALTED: ;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= RUN;
            pc              <= RESET_PC;
            if_id_instr     <= NOP_INSTR;
            if_id_pc_plus_2 <= '0;
            if_id_valid     <= 1'b0;
            fetch_count     <= '0;
        end else begin
            state           <= state_nxt;
            pc              <= pc_nxt;
            if_id_instr     <= instr_nxt;
            if_id_pc_plus_2 <= pp2_nxt;
            if_id_valid     <= valid_nxt;
            fetch_count     <= count_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand sequences,
// then randomized traffic against a behavioural model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [15:0] redirect_pc, imem_data, drv_data;
    logic [15:0] imem_addr, pc, if_id_instr, if_id_pc_plus_2, fetch_count;
    logic        if_id_valid, hlt;
    logic        use_mem;
    logic [15:0] mem [0:255];

    int unsigned total = 0;
    int unsigned bad   = 0;

    // behavioural model state
    logic [15:0] m_pc, m_instr, m_pp2, m_count;
    logic        m_valid, m_pend, m_halted;

    always #5 clk = ~clk;

    always_comb imem_data = use_mem ? mem[imem_addr[8:1]] : drv_data;

    fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_pc(redirect_pc), .imem_data(imem_data),
        .imem_addr(imem_addr), .pc(pc), .if_id_instr(if_id_instr),
        .if_id_pc_plus_2(if_id_pc_plus_2), .if_id_valid(if_id_valid),
        .hlt(hlt), .fetch_count(fetch_count)
    );

    typedef struct {
        logic        r, s, f;
        logic [15:0] redir, data;
        logic [15:0] pc, instr, pp2;
        logic        valid, hlt;
        logic [15:0] count;
    } vec_t;
    vec_t vecs [$];

    task automatic add(input logic r, s, f, input logic [15:0] redir, data,
                       input logic [15:0] epc, einstr, epp2,
                       input logic ev, eh, input logic [15:0] ecnt);
        vec_t v;
        v = '{r, s, f, redir, data, epc, einstr, epp2, ev, eh, ecnt};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] epc, einstr, epp2,
                           input logic ev, eh, input logic [15:0] ecnt);
        chk({tag, " pc"}, pc, epc);
        chk({tag, " imem_addr"}, imem_addr, epc);
        chk({tag, " instr"}, if_id_instr, einstr);
        chk({tag, " pp2"}, if_id_pc_plus_2, epp2);
        chk({tag, " valid"}, {15'd0, if_id_valid}, {15'd0, ev});
        chk({tag, " hlt"}, {15'd0, hlt}, {15'd0, eh});
        chk({tag, " count"}, fetch_count, ecnt);
    endtask

    task automatic drive(input logic r, s, f, input logic [15:0] redir, data);
        rst = r; stall = s; flush = f; redirect_pc = redir; drv_data = data;
        @(posedge clk);
        #1;
    endtask

    task automatic model_edge(input logic r, s, f, input logic [15:0] redir, d);
        if (r) begin
            m_pc = 16'h0000; m_instr = 16'h0000; m_pp2 = 16'h0000; m_count = 16'h0000;
            m_valid = 1'b0; m_pend = 1'b0; m_halted = 1'b0;
        end else if (m_halted) begin
            // frozen until reset
        end else if (f) begin
            m_pc = redir & 16'hFFFE; m_instr = 16'h0000; m_pp2 = 16'h0000;
            m_valid = 1'b0; m_pend = 1'b0;
        end else if (s) begin
            // hold
        end else if (m_pend) begin
            m_pend = 1'b0; m_halted = 1'b1;
            m_instr = 16'h0000; m_pp2 = 16'h0000; m_valid = 1'b0;
        end else begin
            m_instr = d; m_pp2 = m_pc + 16'd2; m_valid = 1'b1; m_count = m_count + 16'd1;
            if (d[15:12] == 4'hF) m_pend = 1'b1;
            else                  m_pc = m_pc + 16'd2;
        end
    endtask

    initial begin
        use_mem = 1'b0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = '0; drv_data = '0;
        for (int unsigned i = 0; i < 256; i++) mem[i] = 16'h0000;

        //   r s f redir     data      | pc        instr     pp2      v h count
        add(1,0,0,16'h0000,16'h0000,   16'h0000,16'h0000,16'h0000,0,0,16'd0);
        add(0,0,0,16'h0000,16'h1123,   16'h0002,16'h1123,16'h0002,1,0,16'd1);
        add(0,0,0,16'h0000,16'h1123,   16'h0004,16'h1123,16'h0004,1,0,16'd2);
        add(0,0,0,16'h0000,16'h1123,   16'h0006,16'h1123,16'h0006,1,0,16'd3);
        add(0,1,0,16'h0000,16'h2222,   16'h0006,16'h1123,16'h0006,1,0,16'd3);
        add(0,1,0,16'h0000,16'h2222,   16'h0006,16'h1123,16'h0006,1,0,16'd3);
        add(0,0,0,16'h0000,16'h3333,   16'h0008,16'h3333,16'h0008,1,0,16'd4);
        add(0,0,0,16'h0000,16'h4444,   16'h000A,16'h4444,16'h000A,1,0,16'd5);
        add(0,0,0,16'h0000,16'h5555,   16'h000C,16'h5555,16'h000C,1,0,16'd6);
        add(0,0,0,16'h0000,16'hF000,   16'h000C,16'hF000,16'h000E,1,0,16'd7);
        add(0,1,0,16'h0000,16'hF000,   16'h000C,16'hF000,16'h000E,1,0,16'd7);
        add(0,0,0,16'h0000,16'h1111,   16'h000C,16'h0000,16'h0000,0,1,16'd7);
        add(0,1,1,16'h0100,16'h1111,   16'h000C,16'h0000,16'h0000,0,1,16'd7);
        add(0,0,1,16'h0200,16'h1111,   16'h000C,16'h0000,16'h0000,0,1,16'd7);
        add(1,0,0,16'h0000,16'h1111,   16'h0000,16'h0000,16'h0000,0,0,16'd0);
        add(0,0,1,16'h000E,16'h9999,   16'h000E,16'h0000,16'h0000,0,0,16'd0);
        add(0,0,0,16'h0000,16'h7777,   16'h0010,16'h7777,16'h0010,1,0,16'd1);
        add(0,1,1,16'h0041,16'h8888,   16'h0040,16'h0000,16'h0000,0,0,16'd1);
        add(0,0,0,16'h0000,16'hABCD,   16'h0042,16'hABCD,16'h0042,1,0,16'd2);
        add(0,0,0,16'h0000,16'hF123,   16'h0042,16'hF123,16'h0044,1,0,16'd3);
        add(0,0,1,16'h0020,16'h5555,   16'h0020,16'h0000,16'h0000,0,0,16'd3);
        add(0,0,0,16'h0000,16'h1234,   16'h0022,16'h1234,16'h0022,1,0,16'd4);
        add(1,1,0,16'h0000,16'h1234,   16'h0000,16'h0000,16'h0000,0,0,16'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].s, vecs[i].f, vecs[i].redir, vecs[i].data);
            chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].pp2,
                    vecs[i].valid, vecs[i].hlt, vecs[i].count);
        end

        // PC wrap through 0xFFFE, redirect bit 0 dropped
        drive(0, 0, 1, 16'hFFFF, 16'h0000);
        chk_all("wrap_redir", 16'hFFFE, 16'h0000, 16'h0000, 0, 0, 16'd0);
        drive(0, 0, 0, 16'h0000, 16'h1111);
        chk_all("wrap_fetch", 16'h0000, 16'h1111, 16'h0000, 1, 0, 16'd1);
        // reset while stalled in HALT_PEND
        drive(0, 0, 0, 16'h0000, 16'hF00F);
        chk_all("pend", 16'h0000, 16'hF00F, 16'h0002, 1, 0, 16'd2);
        drive(1, 1, 0, 16'h0000, 16'hF00F);
        chk_all("rst_pend", 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0);

        // randomized traffic against the model
        for (int unsigned i = 0; i < 256; i++) mem[i] = 16'($urandom);
        use_mem = 1'b1;
        for (int unsigned cyc = 0; cyc < 600; cyc++) begin
            logic        r, s, f;
            logic [15:0] rd;
            r  = (cyc == 0) || ($urandom_range(0, 40) == 0) ||
                 (m_halted && $urandom_range(0, 3) == 0);
            s  = ($urandom_range(0, 4) == 0);
            f  = ($urandom_range(0, 6) == 0);
            rd = 16'($urandom);
            model_edge(r, s, f, rd, mem[m_pc[8:1]]);
            drive(r, s, f, rd, 16'h0000);
            chk_all("rand", m_pc, m_instr, m_pp2, m_valid, m_halted, m_count);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined WISC-S25 CPU. Owns the PC register, drives the instruction-memory read address, and loads the IF/ID pipeline register that feeds decode. Handles hazard stalls, branch-redirect flushes and HLT detection, so the PC sequence seen by the CPU-level bench is produced here.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `NOP_INSTR`, 16'h0000, instruction word injected into IF/ID on flush or bubble.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset. One clock, `clk`; reset is synchronous and active-high.
- `stall`  input  1  hazard unit request; hold PC and IF/ID.
- `flush`  input  1  taken branch resolved in decode; redirect fetch.
- `redirect_pc`  input  16  branch target (PC+2+imm<<1 or register value); valid with `flush`.
- `imem_data`  input  16  instruction word read at `imem_addr`; combinational, same cycle.
- `imem_addr`  output  16  equals `pc`.
- `pc`  output  16  current fetch PC.
- `if_id_instr`  output  16  registered instruction for decode.
- `if_id_pc_plus_2`  output  16  registered PC+2 of that instruction (PCS/branch base).
- `if_id_valid`  output  1  IF/ID holds a real instruction.
- `hlt`  output  1  CPU halted; held until reset.
- `fetch_count`  output  16  number of instructions loaded into IF/ID with valid=1.

## Operation
- FSM states: RUN, HALT_PEND, HALTED.
- RUN, no stall/flush: IF/ID <= {imem_data, pc+2, valid=1}; pc <= pc+2; fetch_count += 1.
- HLT detect: in RUN, if imem_data[15:12]==4'hF and no stall/flush: load it into IF/ID (valid=1), pc holds, go HALT_PEND.
- HALT_PEND: no new fetch; pc holds. Flush -> apply redirect, return RUN (HLT was wrong-path). Stall -> remain, IF/ID holds. Otherwise -> HALTED, IF/ID <= NOP, valid=0.
- HALTED: pc, IF/ID, fetch_count frozen; `hlt`=1; ignores stall/flush; exits only via rst.
- Priority each cycle: rst > flush > stall > normal fetch.
- Flush: pc <= {redirect_pc[15:1],1'b0}; IF/ID <= {NOP_INSTR, 16'h0000, valid=0}; count unchanged. Flush with stall: flush wins.
- Stall: pc, IF/ID, count, state unchanged.
- Arithmetic: pc+2 modulo 2^16 (0xFFFE -> 0x0000); fetch_count wraps 0xFFFF -> 0x0000. pc[0] always 0.

## Timing
- Reset values: pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc_plus_2=0, if_id_valid=0, hlt=0, fetch_count=0, state RUN.
- Fetch latency: instruction at pc appears on IF/ID one edge after it is addressed.
- Redirect latency: `flush` sampled at edge N -> pc=redirect target after N, target instruction on IF/ID after edge N+1; exactly one bubble.
- `hlt` asserts the cycle after leaving HALT_PEND, i.e. 2 edges after HLT fetched (no stall/flush).
- `imem_addr` combinational from pc register; no path from inputs to outputs except imem_addr=pc.
- rst mid-operation (any state, incl. HALTED or during stall): all outputs to reset values on that edge.

## Test plan
- Reset then free-run, imem holds 0x1123 at every address: pc 0,2,4,6; if_id_pc_plus_2 2,4,6; valid=1 from 2nd edge; fetch_count=3 after 3 fetch edges.
- Stall 2 cycles at pc=0x0006: pc stays 0x0006, IF/ID and count unchanged; on release next edge pc=0x0008.
- Flush with redirect_pc=0x0041 at pc=0x0010, stall also high: pc=0x0040, if_id_valid=0, if_id_instr=0x0000; next edge IF/ID carries word at 0x0040, pc_plus_2=0x0042.
- HLT 0xF000 at 0x000C: IF/ID gets 0xF000 valid, pc stays 0x000C; next edge hlt=1, valid=0; further stall/flush ignored; rst returns pc=0, hlt=0.
- HLT fetched wrong-path: flush redirect_pc=0x0020 in HALT_PEND -> state RUN, pc=0x0020, hlt stays 0.
- Wrap: redirect to 0xFFFE, no stall -> next pc=0x0000, if_id_pc_plus_2=0x0000.
